// File: rtl/evr_log_sequencer.sv
// Event-receiver log sequencer: pulls codes from the event-log FIFO, filters them
// through a 256-bit mask and stores {timestamp, code} entries in a capture buffer.
module evr_log_sequencer #(
  parameter int ADDR_WIDTH = 9,
  parameter     DEBUG      = "false"
) (
  input  logic        sysClk,
  input  logic        sysReset,
  input  logic [31:0] GPIO_OUT,
  input  logic        csrStrobe,
  output logic [31:0] csrStatus,
  output logic [31:0] csrData,
  output logic        fifoRdEnable,
  input  logic        fifoEmpty,
  input  logic [7:0]  fifoData
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, WAIT, STORE} state_t;

  (* mark_debug = DEBUG *) state_t state_q, state_d;

  logic                  enable_q, enable_d;
  logic [255:0]          mask_q, mask_d;
  logic [23:0]           ts_q, ts_d;
  logic [23:0]           ts_lat_q, ts_lat_d;
  logic [7:0]            code_q, code_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [7:0]            drop_q, drop_d;
  logic [31:0]           csr_data_q, csr_data_d;

  logic [31:0] mem [DEPTH];

  logic cmd_mask, cmd_ctrl, cmd_pop, clear;
  logic buf_full, buf_empty;
  logic wr_en, pop_en;
  logic unused_bits;

  always_comb begin
    cmd_mask    = csrStrobe && (GPIO_OUT[31:30] == 2'b00);
    cmd_ctrl    = csrStrobe && (GPIO_OUT[31:30] == 2'b01);
    cmd_pop     = csrStrobe && (GPIO_OUT[31:30] == 2'b10);
    clear       = cmd_ctrl && GPIO_OUT[1];
    buf_empty   = (count_q == '0);
    buf_full    = (count_q == CW'(DEPTH));
    unused_bits = ^{GPIO_OUT[29:9], DEBUG};
  end

  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    mask_d   = mask_q;
    ts_d     = ts_q + 24'd1;
    ts_lat_d = ts_lat_q;
    code_d   = code_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    wr_en    = 1'b0;
    pop_en   = 1'b0;

    if (cmd_mask) mask_d[GPIO_OUT[7:0]] = GPIO_OUT[8];
    if (cmd_ctrl) enable_d = GPIO_OUT[0];

    // enable gates only the IDLE exit, so a started read always completes
    unique case (state_q)
      IDLE:  if (enable_q && !fifoEmpty) state_d = READ;
      READ: begin
        ts_lat_d = ts_q;
        state_d  = WAIT;
      end
      WAIT: begin
        code_d  = fifoData;
        state_d = STORE;
      end
      STORE: begin
        state_d = IDLE;
        if (mask_q[code_q]) begin
          if (!buf_full)             wr_en  = 1'b1;
          else if (drop_q != 8'hFF)  drop_d = drop_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    pop_en = cmd_pop && !buf_empty;
    if (wr_en)  wptr_d = wptr_q + ADDR_WIDTH'(1);
    if (pop_en) rptr_d = rptr_q + ADDR_WIDTH'(1);
    if (wr_en && !pop_en)      count_d = count_q + CW'(1);
    else if (!wr_en && pop_en) count_d = count_q - CW'(1);

    // clear aborts any in-flight entry by returning the FSM to IDLE
    if (clear) begin
      wr_en   = 1'b0;
      state_d = IDLE;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      drop_d  = '0;
      ts_d    = '0;
    end

    csr_data_d = buf_empty ? '0 : mem[rptr_q];
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state_q    <= IDLE;
      enable_q   <= 1'b0;
      mask_q     <= '0;
      ts_q       <= '0;
      ts_lat_q   <= '0;
      code_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      csr_data_q <= '0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      mask_q     <= mask_d;
      ts_q       <= ts_d;
      ts_lat_q   <= ts_lat_d;
      code_q     <= code_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      csr_data_q <= csr_data_d;
    end
  end

  always_ff @(posedge sysClk) begin
    if (wr_en) mem[wptr_q] <= {ts_lat_q, code_q};
  end

  always_comb begin
    fifoRdEnable = (state_q == READ) && !fifoEmpty;
    csrData      = csr_data_q;
    csrStatus    = {enable_q, buf_empty, buf_full, drop_q, 11'b0, 10'(count_q)};
  end

endmodule

// File: tb/tb_evr_log_sequencer.sv
// Bench for evr_log_sequencer: table of command/push vectors plus hand-written
// sequences for pop-during-store, clear-during-wait, enable drop and async reset.
module tb_evr_log_sequencer;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic [31:0] gpio   = {2'b11, 30'h0};
  logic        strobe = 1'b0;
  logic [31:0] status, data;
  logic        fifo_rd, fifo_empty;
  logic [7:0]  fifo_data;

  always #5 clk = ~clk;

  evr_log_sequencer #(.ADDR_WIDTH(AW), .DEBUG("false")) dut (
    .sysClk      (clk),
    .sysReset    (rst),
    .GPIO_OUT    (gpio),
    .csrStrobe   (strobe),
    .csrStatus   (status),
    .csrData     (data),
    .fifoRdEnable(fifo_rd),
    .fifoEmpty   (fifo_empty),
    .fifoData    (fifo_data)
  );

  // Event-log FIFO model: data appears one cycle after the read request.
  logic [7:0] fmem [256];
  int fwp = 0;
  int frp = 0;
  assign fifo_empty = (fwp == frp);
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= fmem[frp];
      frp       <= frp + 1;
    end
  end

  // Timestamp model and read-pulse bookkeeping.
  logic [23:0] ts_model;
  logic [23:0] last_rd_ts = '0;
  int          rd_pulses  = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) ts_model <= '0;
    else begin
      if (fifo_rd) begin
        rd_pulses  <= rd_pulses + 1;
        last_rd_ts <= ts_model;
      end
      if (strobe && gpio[31:30] == 2'b01 && gpio[1]) ts_model <= '0;
      else                                           ts_model <= ts_model + 24'd1;
    end
  end

  int         n_vec = 0;
  int         n_err = 0;
  bit [255:0] mask_m = '0;
  int         cnt_m  = 0;
  logic [7:0] exp_q [$];

  function automatic logic [31:0] st(input bit en, input bit em, input bit fu,
                                     input logic [7:0] dr, input int cnt);
    return {en, em, fu, dr, 11'b0, cnt[9:0]};
  endfunction
  function automatic logic [31:0] ctrl(input bit en, input bit clr);
    return {2'b01, 28'h0, clr, en};
  endfunction
  function automatic logic [31:0] maskw(input logic [7:0] code, input bit b);
    return {2'b00, 21'h0, b, code};
  endfunction
  localparam logic [31:0] POP = {2'b10, 30'h0};
  localparam logic [31:0] NOP = {2'b11, 30'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] code, input bit model);
    fmem[fwp] = code;
    fwp++;
    if (model && mask_m[code] && cnt_m < DEPTH) begin
      exp_q.push_back(code);
      cnt_m++;
    end
  endtask

  task automatic do_cmd(input logic [31:0] c);
    logic [7:0] head;
    if (c[31:30] == 2'b10) begin
      if (cnt_m > 0) begin
        head = exp_q.pop_front();
        cnt_m--;
        chk("pop_head", {24'h0, data[7:0]}, {24'h0, head});
      end
    end else if (c[31:30] == 2'b00) begin
      mask_m[c[7:0]] = c[8];
    end else if (c[31:30] == 2'b01 && c[1]) begin
      cnt_m = 0;
      exp_q.delete();
    end
    @(negedge clk);
    gpio   = c;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    gpio   = NOP;
    if (c[31:30] == 2'b10) repeat (2) @(negedge clk);
  endtask

  task automatic wait_read(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (fifo_rd) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: fifoRdEnable got 0 within 20 cycles, expected 1", name);
    end
  endtask

  typedef struct {
    logic [31:0] cmd;
    int          rep;
    bit          inc;
    int          npush;
    logic [7:0]  code0;
    int          settle;
    logic [31:0] exp_status;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    logic [31:0] c;
    int          p;

    vecs = '{
      '{ctrl(1, 0),       1,   1'b0, 1,  8'h7D, 10,  st(1, 1, 0, 8'd0, 0)},
      '{maskw(8'h7D, 1),  1,   1'b0, 0,  8'h00, 3,   st(1, 1, 0, 8'd0, 0)},
      '{NOP,              1,   1'b0, 1,  8'h7D, 10,  st(1, 0, 0, 8'd0, 1)},
      '{POP,              1,   1'b0, 0,  8'h00, 3,   st(1, 1, 0, 8'd0, 0)},
      '{maskw(8'h00, 1),  256, 1'b1, 0,  8'h00, 3,   st(1, 1, 0, 8'd0, 0)},
      '{ctrl(1, 1),       1,   1'b0, 0,  8'h00, 3,   st(1, 1, 0, 8'd0, 0)},
      '{NOP,              1,   1'b0, 20, 8'h10, 100, st(1, 0, 1, 8'd4, 16)},
      '{POP,              16,  1'b0, 0,  8'h00, 3,   st(1, 1, 0, 8'd4, 0)},
      '{POP,              1,   1'b0, 0,  8'h00, 3,   st(1, 1, 0, 8'd4, 0)},
      '{ctrl(1, 1),       1,   1'b0, 0,  8'h00, 3,   st(1, 1, 0, 8'd0, 0)},
      '{NOP,              1,   1'b0, 3,  8'h40, 30,  st(1, 0, 0, 8'd0, 3)}
    };

    repeat (2) @(negedge clk);
    chk("reset_status", status, 32'h4000_0000);
    chk("reset_data", data, 32'h0);
    chk("reset_rd", {31'h0, fifo_rd}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < vecs[i].npush; k++) push(vecs[i].code0 + 8'(k), 1'b1);
      for (int r = 0; r < vecs[i].rep; r++) begin
        c = vecs[i].cmd;
        if (vecs[i].inc) c[7:0] = 8'(r);
        do_cmd(c);
      end
      repeat (vecs[i].settle) @(negedge clk);
      chk($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
      if (i == 0) chk("masked_off_single_read", 32'(rd_pulses), 32'd1);
      if (i == 2) chk("entry_ts_code", data, {last_rd_ts, 8'h7D});
    end

    // Pop lands in the STORE cycle with three entries buffered.
    push(8'h50, 1'b1);
    wait_read("pop_store_read");
    @(negedge clk);
    do_cmd(POP);
    repeat (3) @(negedge clk);
    chk("pop_store_status", status, st(1, 0, 0, 8'd0, 3));
    chk("pop_store_head", {24'h0, data[7:0]}, {24'h0, exp_q[0]});

    // Clear during WAIT drops the in-flight entry and restarts the timestamp.
    push(8'h60, 1'b0);
    wait_read("clr_wait_read");
    do_cmd(ctrl(1, 1));
    repeat (10) @(negedge clk);
    chk("clr_wait_status", status, st(1, 1, 0, 8'd0, 0));
    push(8'h61, 1'b1);
    wait_read("post_clr_read");
    repeat (6) @(negedge clk);
    chk("post_clr_status", status, st(1, 0, 0, 8'd0, 1));
    chk("post_clr_entry", data, {last_rd_ts, 8'h61});

    // Disable mid-sequence: the entry in flight is still stored, then the FSM idles.
    push(8'h62, 1'b1);
    wait_read("dis_read");
    do_cmd(ctrl(0, 0));
    repeat (6) @(negedge clk);
    chk("dis_status", status, st(0, 0, 0, 8'd0, 2));
    p = rd_pulses;
    push(8'h63, 1'b0);
    repeat (10) @(negedge clk);
    chk("dis_no_read", 32'(rd_pulses), 32'(p));
    chk("dis_head", {24'h0, data[7:0]}, {24'h0, exp_q[0]});

    // Asynchronous reset mid-READ.
    do_cmd(ctrl(1, 0));
    wait_read("rst_read");
    #1 rst = 1'b1;
    #1;
    chk("rst_rd_drop", {31'h0, fifo_rd}, 32'h0);
    chk("rst_status", status, 32'h4000_0000);
    chk("rst_data", data, 32'h0);
    cnt_m  = 0;
    exp_q.delete();
    mask_m = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hold_status", status, 32'h4000_0000);
    p = rd_pulses;
    do_cmd(ctrl(1, 0));
    repeat (10) @(negedge clk);
    chk("rst_mask_cleared", status, st(1, 1, 0, 8'd0, 0));
    chk("rst_pending_read", 32'(rd_pulses), 32'(p + 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
